// File: rtl/data_mem_responder.sv
// data_mem_responder
//
// Memory side of the core's MEM-stage load/store port. It accepts one request
// at a time, performs the access LATENCY cycles after acceptance, and returns
// load data or an error. It owns word storage, byte-lane steering for
// sub-word stores and loads, and alignment/range checking. Sign/zero extension
// of load data is left to the core. Load data is right-aligned and zero-filled.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid / req_ready    request handshake
//   req_write                1 = store, 0 = load
//   req_size                 00 byte, 01 half, 10 word, 11 illegal
//   req_addr, req_wdata      byte address, right-aligned store data
//   resp_valid / resp_ready  response handshake
//   resp_rdata, resp_err     load data (0 for stores/errors), error flag
//   dbg_state                current FSM state (IDLE=0, BUSY=1, RESP=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is high only in IDLE. resp_valid is high only in RESP,
// and resp_rdata/resp_err hold stable there until resp_ready is seen. A
// response and a new request are never exchanged on the same edge.
//
// Storage words are WIDTH bits wide and split into four byte lanes, so WIDTH
// is expected to be 32.

module data_mem_responder #(
    parameter int WIDTH       = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic [1:0]       dbg_state
);

    localparam int NB    = WIDTH / 8;
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [1:0]       size_q, size_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    // Storage is deliberately outside the reset domain: contents survive rst.
    logic [WIDTH-1:0] mem [DEPTH_WORDS];

    logic [1:0]       off;
    logic             in_range;
    logic             acc_err;
    logic [IDX_W-1:0] word_idx;
    logic [WIDTH-1:0] old_word;
    logic [WIDTH-1:0] new_word;
    logic [WIDTH-1:0] wlanes;
    logic [NB-1:0]    be;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] load_data;
    logic             mem_we;

    assign off      = addr_q[1:0];
    assign in_range = addr_q[WIDTH-1:2] < (WIDTH-2)'(DEPTH_WORDS);
    assign acc_err  = (size_q == 2'b11)
                    | ((size_q == SZ_HALF) & off[0])
                    | ((size_q == SZ_WORD) & (off != 2'b00))
                    | ~in_range;
    assign word_idx = addr_q[IDX_W+1:2];
    assign old_word = mem[word_idx];

    // Store data is replicated across lanes so whichever lanes are enabled
    // already see the right byte without a separate shifter.
    always_comb begin
        be     = '0;
        wlanes = wdata_q;
        case (size_q)
            SZ_BYTE: begin
                be     = NB'(1) << off;
                wlanes = {NB{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                be     = NB'(3) << off;
                wlanes = {(NB/2){wdata_q[15:0]}};
            end
            SZ_WORD: begin
                be     = '1;
                wlanes = wdata_q;
            end
            default: be = '0;
        endcase
    end

    always_comb begin
        new_word = old_word;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) new_word[8*k +: 8] = wlanes[8*k +: 8];
        end
    end

    assign shifted = old_word >> {off, 3'b000};

    always_comb begin
        load_data = '0;
        case (size_q)
            SZ_BYTE: load_data = {{(WIDTH-8){1'b0}}, shifted[7:0]};
            SZ_HALF: load_data = {{(WIDTH-16){1'b0}}, shifted[15:0]};
            SZ_WORD: load_data = shifted;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Commit: a failed check suppresses the write entirely.
                    err_d   = acc_err;
                    rdata_d = (acc_err || write_q) ? '0 : load_data;
                    mem_we  = write_q && !acc_err;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // mem_we comes from state_q, which reset forces to IDLE, so a store
    // pending in BUSY is dropped when reset arrives.
    always_ff @(posedge clk) begin
        if (mem_we) mem[word_idx] <= new_word;
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the pipelined RISC-V core: it is the memory side of the MEM-stage load/store port, accepting one request at a time over a valid/ready handshake, performing the access after a configurable latency, and returning read data or an error over a second valid/ready handshake. It owns word storage, byte-lane steering for sb/sh/lb/lh, and alignment/range checking. Sign or zero extension of load data stays in the core.

## Interface
- WIDTH, 32, data and address width.
- DEPTH_WORDS, 1024, number of 32-bit storage words.
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_addr  in  WIDTH  byte address.
- req_wdata  in  WIDTH  store data, right-aligned; only the low 8/16/32 bits are used.
- resp_valid  out  1  response present.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  WIDTH  load data, right-aligned and zero-filled above the access size; 0 for stores and errors.
- resp_err  out  1  access was misaligned, out of range, or had illegal size.

## Operation
- FSM states: IDLE, BUSY, RESP. A single request is outstanding at a time.
- IDLE: req_ready=1. When req_valid is high, the request is accepted: req_write, req_size, req_addr and req_wdata are latched, the counter is loaded with LATENCY-1, and the FSM moves to BUSY.
- BUSY: req_ready=0. If the counter is nonzero, it decrements. If it is 0, the access is committed, resp_rdata and resp_err are registered, and the FSM moves to RESP.
- RESP: resp_valid=1. resp_rdata and resp_err hold stable until resp_ready is high, and the FSM then moves to IDLE.
- Error check, evaluated at commit:
  - half-word with addr[0]=1;
  - word with addr[1:0]≠0;
  - size 11;
  - addr[31:2] ≥ DEPTH_WORDS.
- On error: no write occurs, resp_rdata=0, resp_err=1.
- Store: the byte enable for a byte store is 1 shifted left by addr[1:0]. The byte enables for a half-word store are 0011 shifted left by addr[1:0]. A word store enables all lanes. The write data is replicated or shifted so that lane k receives the correct byte. Only enabled lanes change.
- Load: resp_rdata is the addressed word shifted right by 8*addr[1:0], then masked to 8, 16 or 32 bits.
- The write and the read for a commit use the same word, so a load that follows a store to the same address returns the new data.

## Timing
- Reset values: FSM=IDLE, counter=0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0. Storage contents are not reset and are preserved across reset.
- If a request is accepted at edge T, resp_valid rises after edge T+LATENCY.
- The store commits on edge T+LATENCY.
- Minimum request period is LATENCY+2 cycles, when resp_ready is held high.
- There is no same-cycle response/accept overlap: req_ready stays 0 in RESP.
- Reset asserted in BUSY: the pending store is dropped and storage is unchanged. Reset asserted in RESP: the response is discarded and the store has already been committed.
- req_* inputs are ignored outside IDLE, and changes to them after acceptance have no effect.
- resp_ready is ignored outside RESP.

## Test plan
- Write then read word: store 0xDEADBEEF to 0x10, then load word from 0x10 → resp_rdata=0xDEADBEEF, resp_err=0, and resp_valid rises exactly LATENCY edges after each accept.
- Byte lanes: after the word above, store byte 0x5A to 0x12, then load word from 0x10 → 0xDE5ABEEF. Load byte from 0x13 → 0x000000DE. Load half from 0x12 → 0x0000DE5A.
- Misalignment and range: load half from 0x11, store word to 0x16, access 4*DEPTH_WORDS, and use size 11 → resp_err=1 and resp_rdata=0 in each case. A readback shows memory unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP → resp_valid, resp_rdata and resp_err stay stable and req_ready=0. The response releases on the first cycle with resp_ready=1, and req_ready=1 on the next cycle.
- Reset mid-operation: accept a store of 0x12345678 to 0x20 with LATENCY=3, then pulse rst low one cycle after accept → outputs return to reset values, and a later load of 0x20 returns the prior contents.
- LATENCY=1 back-to-back: issue 4 requests with resp_ready tied high → each response arrives 1 edge after its accept, and requests are accepted every 3 cycles.
